lcd_video_capture: RTL

Receive-side counterpart of the DE-mode RGB565 LCD timing generator: samples a parallel `pclk`/`de`/`rgb565` video bus on the board's system clock and recovers the pixel stream with `(x,y)` coordinates. It measures line length and frame height, flags timing errors, and reports lock. It sits between a connector carrying another board's LCD bus (or a loopback of our own generator) and downstream frame-buffer or checker logic.

---
 rtl/lcd_video_capture.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/lcd_video_capture.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_video_capture
//  Purpose  : Samples a DE-mode RGB565 LCD bus (pclk/de/rgb565) on the system
//             clock and recovers pixels with (x,y) coordinates. Measures line
//             length and frame height, flags timing errors and reports lock.
//  Revision : 1.0  initial release
// ============================================================================
module lcd_video_capture #(
  parameter int H_ACTIVE     = 480,
  parameter int V_ACTIVE     = 272,
  parameter int VBLANK_MIN   = 1024,
  parameter int PCLK_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pclk,
  input  logic        de,
  input  logic [15:0] rgb565,
  output logic        pix_valid,
  output logic [15:0] pix_data,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic        sof,
  output logic        line_done,
  output logic [9:0]  line_len,
  output logic        frame_done,
  output logic [8:0]  frame_lines,
  output logic        err_width,
  output logic        err_height,
  output logic        locked
);

  localparam int BW = $clog2(VBLANK_MIN + 1);
  localparam int TW = $clog2(PCLK_TIMEOUT + 1);

  localparam logic [BW-1:0] c_vbmin   = BW'(VBLANK_MIN);
  localparam logic [TW-1:0] c_timeout = TW'(PCLK_TIMEOUT);
  localparam logic [9:0]    c_h       = 10'(H_ACTIVE);
  localparam logic [8:0]    c_v       = 9'(V_ACTIVE);
  localparam logic [9:0]    c_x_max   = 10'h3FF;
  localparam logic [8:0]    c_y_max   = 9'h1FF;

  localparam logic [1:0] c_st_search = 2'd0;
  localparam logic [1:0] c_st_vblank = 2'd1;
  localparam logic [1:0] c_st_active = 2'd2;
  localparam logic [1:0] c_st_hblank = 2'd3;

  // Synchronizers: pclk gets a third stage for edge detection
  logic [2:0]    pclk_s_q;
  logic [1:0]    de_s_q;
  logic [15:0]   rgb_s1_q, rgb_s2_q;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] to_q;
  logic [BW-1:0] blank_q, blank_d;
  logic [9:0]    x_q, x_d;
  logic [8:0]    line_q, line_d;
  logic          ferr_q, ferr_d;

  logic          pix_valid_q, pix_valid_d;
  logic [15:0]   pix_data_q, pix_data_d;
  logic [9:0]    pix_x_q, pix_x_d;
  logic [8:0]    pix_y_q, pix_y_d;
  logic          sof_q, sof_d;
  logic          line_done_q, line_done_d;
  logic [9:0]    line_len_q, line_len_d;
  logic          frame_done_q, frame_done_d;
  logic [8:0]    frame_lines_q, frame_lines_d;
  logic          err_width_q, err_width_d;
  logic          err_height_q, err_height_d;
  logic          locked_q, locked_d;

  logic          w_sample, w_edge, w_de, w_timeout, w_vb_hit;
  logic [BW-1:0] w_blank_inc;
  logic [9:0]    w_x_inc;
  logic [8:0]    w_line_inc;

  // Sample event is a falling edge of synchronized pclk; any edge feeds the watchdog
  assign w_sample    = ~pclk_s_q[1] & pclk_s_q[2];
  assign w_edge      = pclk_s_q[1] ^ pclk_s_q[2];
  assign w_de        = de_s_q[1];
  assign w_timeout   = (to_q == c_timeout);
  assign w_blank_inc = (blank_q == c_vbmin) ? blank_q : blank_q + BW'(1);
  assign w_vb_hit    = (w_blank_inc == c_vbmin);
  assign w_x_inc     = (x_q == c_x_max) ? x_q : x_q + 10'd1;
  assign w_line_inc  = (line_q == c_y_max) ? line_q : line_q + 9'd1;

  // Bring the asynchronous video bus into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pclk_s_q <= '0;
      de_s_q   <= '0;
      rgb_s1_q <= '0;
      rgb_s2_q <= '0;
    end else begin
      pclk_s_q <= {pclk_s_q[1:0], pclk};
      de_s_q   <= {de_s_q[0], de};
      rgb_s1_q <= rgb565;
      rgb_s2_q <= rgb_s1_q;
    end
  end

  // Watchdog: counts clk cycles since the last pclk edge, saturating at the limit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_q <= '0;
    end else if (w_edge) begin
      to_q <= '0;
    end else if (!w_timeout) begin
      to_q <= to_q + TW'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_st_search;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; a stalled pclk always falls back to SEARCH
  always_comb begin
    state_d = state_q;
    if (w_timeout) begin
      state_d = c_st_search;
    end else if (w_sample) begin
      case (state_q)
        c_st_search: if (!w_de && w_vb_hit) state_d = c_st_vblank;
        c_st_vblank: if (w_de) state_d = c_st_active;
        c_st_active: if (!w_de) state_d = c_st_hblank;
        c_st_hblank: begin
          if (w_de)          state_d = c_st_active;
          else if (w_vb_hit) state_d = c_st_vblank;
        end
        default:             state_d = c_st_search;
      endcase
    end
  end

  // FSM output logic: strobes, coordinates, measurements and lock tracking
  always_comb begin
    blank_d       = blank_q;
    x_d           = x_q;
    line_d        = line_q;
    ferr_d        = ferr_q;
    pix_valid_d   = 1'b0;
    pix_data_d    = pix_data_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    sof_d         = sof_q;
    line_done_d   = 1'b0;
    line_len_d    = line_len_q;
    frame_done_d  = 1'b0;
    frame_lines_d = frame_lines_q;
    err_width_d   = 1'b0;
    err_height_d  = 1'b0;
    locked_d      = locked_q;
    if (w_timeout) begin
      blank_d  = '0;
      locked_d = 1'b0;
    end else if (w_sample) begin
      blank_d = w_de ? '0 : w_blank_inc;
      case (state_q)
        c_st_search: begin
          // Fresh frame bookkeeping once a genuine vblank is found
          if (!w_de && w_vb_hit) begin
            x_d    = '0;
            line_d = '0;
            ferr_d = 1'b0;
          end
        end
        c_st_vblank: begin
          if (w_de) begin
            pix_valid_d = 1'b1;
            pix_data_d  = rgb_s2_q;
            pix_x_d     = '0;
            pix_y_d     = '0;
            sof_d       = 1'b1;
            x_d         = 10'd1;
          end
        end
        c_st_active: begin
          if (w_de) begin
            pix_valid_d = 1'b1;
            pix_data_d  = rgb_s2_q;
            pix_x_d     = x_q;
            pix_y_d     = line_q;
            sof_d       = 1'b0;
            x_d         = w_x_inc;
          end else begin
            line_done_d = 1'b1;
            line_len_d  = x_q;
            line_d      = w_line_inc;
            if (x_q != c_h) begin
              err_width_d = 1'b1;
              locked_d    = 1'b0;
              ferr_d      = 1'b1;
            end
          end
        end
        default: begin
          if (w_de) begin
            pix_valid_d = 1'b1;
            pix_data_d  = rgb_s2_q;
            pix_x_d     = '0;
            pix_y_d     = line_q;
            sof_d       = 1'b0;
            x_d         = 10'd1;
          end else if (w_vb_hit) begin
            frame_done_d  = 1'b1;
            frame_lines_d = line_q;
            err_height_d  = (line_q != c_v);
            locked_d      = !ferr_q && (line_q == c_v);
            line_d        = '0;
            ferr_d        = 1'b0;
          end
        end
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_q       <= '0;
      x_q           <= '0;
      line_q        <= '0;
      ferr_q        <= 1'b0;
      pix_valid_q   <= 1'b0;
      pix_data_q    <= '0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      sof_q         <= 1'b0;
      line_done_q   <= 1'b0;
      line_len_q    <= '0;
      frame_done_q  <= 1'b0;
      frame_lines_q <= '0;
      err_width_q   <= 1'b0;
      err_height_q  <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      blank_q       <= blank_d;
      x_q           <= x_d;
      line_q        <= line_d;
      ferr_q        <= ferr_d;
      pix_valid_q   <= pix_valid_d;
      pix_data_q    <= pix_data_d;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      sof_q         <= sof_d;
      line_done_q   <= line_done_d;
      line_len_q    <= line_len_d;
      frame_done_q  <= frame_done_d;
      frame_lines_q <= frame_lines_d;
      err_width_q   <= err_width_d;
      err_height_q  <= err_height_d;
      locked_q      <= locked_d;
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign sof         = sof_q;
  assign line_done   = line_done_q;
  assign line_len    = line_len_q;
  assign frame_done  = frame_done_q;
  assign frame_lines = frame_lines_q;
  assign err_width   = err_width_q;
  assign err_height  = err_height_q;
  assign locked      = locked_q;

endmodule
`default_nettype wire
